// File: rtl/eggtimer_ctrl.sv
// eggtimer_ctrl: control FSM for the egg timer.
// Holds the programmed cook time (four BCD digits edited with buttons),
// drives time_count's load/timer_on inputs, detects expiry of the live
// count and holds the alarm for ALARM_SECS one-second ticks.
module eggtimer_ctrl #(
   parameter int unsigned ALARM_SECS = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pulse_1s,
   input  logic       btn_start,
   input  logic       btn_sel,
   input  logic       btn_inc,
   input  logic       btn_clear,
   input  logic [3:0] seconds,
   input  logic [3:0] tens_seconds,
   input  logic [3:0] minutes,
   input  logic [3:0] tens_minutes,
   output logic [3:0] seconds_prog,
   output logic [3:0] tens_seconds_prog,
   output logic [3:0] minutes_prog,
   output logic [3:0] tens_minutes_prog,
   output logic       load,
   output logic       timer_on,
   output logic [1:0] digit_sel,
   output logic       alarm,
   output logic [1:0] state_out
);

   localparam int unsigned      ACNT_W    = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
   localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SECS - 1);
   localparam logic [ACNT_W-1:0] ACNT_ONE  = ACNT_W'(1);
   localparam logic [ACNT_W-1:0] ACNT_ZERO = ACNT_W'(0);

   typedef enum logic [1:0] {
      ST_SET   = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_e;

   // BCD digit increment with wrap at max_val; anything at or above the
   // maximum wraps to zero so an out-of-range value can never persist.
   function automatic logic [3:0] bcd_inc(input logic [3:0] val, input logic [3:0] max_val);
      logic [3:0] res;
      if (val >= max_val) begin
         res = 4'd0;
      end else begin
         res = val + 4'd1;
      end
      return res;
   endfunction

   state_e            state_q, state_d;
   logic [3:0]        sec_q, sec_d;
   logic [3:0]        tsec_q, tsec_d;
   logic [3:0]        min_q, min_d;
   logic [3:0]        tmin_q, tmin_d;
   logic [1:0]        sel_q, sel_d;
   logic [ACNT_W-1:0] acnt_q, acnt_d;
   logic              zero_q;
   logic              load_q, timer_on_q, alarm_q;

   logic              live_zero_s;
   logic              prog_nz_s;
   logic              any_btn_s;

   assign live_zero_s = ({tens_minutes, minutes, tens_seconds, seconds} == 16'h0000);
   assign prog_nz_s   = ({tmin_q, min_q, tsec_q, sec_q} != 16'h0000);
   assign any_btn_s   = btn_start | btn_sel | btn_inc | btn_clear;

   // Next-state, digit editing and alarm counting; clear > start > sel > inc.
   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      tsec_d  = tsec_q;
      min_d   = min_q;
      tmin_d  = tmin_q;
      sel_d   = sel_q;
      acnt_d  = acnt_q;

      case (state_q)
         ST_SET: begin
            if (btn_clear) begin
               sec_d  = 4'd0;
               tsec_d = 4'd0;
               min_d  = 4'd0;
               tmin_d = 4'd0;
               sel_d  = 2'd0;
            end else if (btn_start) begin
               if (prog_nz_s) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_SET;
               end
            end else if (btn_sel) begin
               sel_d = sel_q + 2'd1;
            end else if (btn_inc) begin
               case (sel_q)
                  2'd0:    sec_d  = bcd_inc(sec_q, 4'd9);
                  2'd1:    tsec_d = bcd_inc(tsec_q, 4'd5);
                  2'd2:    min_d  = bcd_inc(min_q, 4'd9);
                  2'd3:    tmin_d = bcd_inc(tmin_q, 4'd9);
                  default: sec_d  = sec_q;
               endcase
            end else begin
               state_d = ST_SET;
            end
         end

         ST_RUN: begin
            if (zero_q) begin
               state_d = ST_ALARM;
               acnt_d  = ACNT_ZERO;
            end else if (btn_clear) begin
               state_d = ST_SET;
            end else if (btn_start) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_PAUSE: begin
            if (btn_clear) begin
               state_d = ST_SET;
            end else if (btn_start) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_PAUSE;
            end
         end

         ST_ALARM: begin
            if (any_btn_s) begin
               state_d = ST_SET;
               acnt_d  = ACNT_ZERO;
            end else if (pulse_1s) begin
               if (acnt_q >= ACNT_LAST) begin
                  state_d = ST_SET;
                  acnt_d  = ACNT_ZERO;
               end else begin
                  acnt_d = acnt_q + ACNT_ONE;
               end
            end else begin
               state_d = ST_ALARM;
            end
         end

         default: begin
            state_d = ST_SET;
            acnt_d  = ACNT_ZERO;
         end
      endcase
   end

   // State, programmed digits, alarm counter and registered output decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_SET;
         sec_q      <= 4'd0;
         tsec_q     <= 4'd0;
         min_q      <= 4'd0;
         tmin_q     <= 4'd0;
         sel_q      <= 2'd0;
         acnt_q     <= ACNT_ZERO;
         load_q     <= 1'b1;
         timer_on_q <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sec_q      <= sec_d;
         tsec_q     <= tsec_d;
         min_q      <= min_d;
         tmin_q     <= tmin_d;
         sel_q      <= sel_d;
         acnt_q     <= acnt_d;
         load_q     <= (state_d == ST_SET);
         timer_on_q <= (state_d == ST_RUN);
         alarm_q    <= (state_d == ST_ALARM);
      end
   end

   // Zero seen while running; gated by RUN so a stale count left over from
   // SET (load lags prog by a cycle) can never trigger a false expiry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= (state_q == ST_RUN) && live_zero_s;
      end
   end

   assign seconds_prog      = sec_q;
   assign tens_seconds_prog = tsec_q;
   assign minutes_prog      = min_q;
   assign tens_minutes_prog = tmin_q;
   assign digit_sel         = sel_q;
   assign load              = load_q;
   assign timer_on          = timer_on_q;
   assign alarm             = alarm_q;
   assign state_out         = state_q;

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Self-checking bench for eggtimer_ctrl: directed scenarios plus a random
// run, with a behavioural model of the controller and of time_count.
module tb_eggtimer_ctrl;

   localparam int ALARM_SECS = 3;
   localparam int S_SET   = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_ALARM = 3;

   logic       clk, reset, pulse_1s;
   logic       btn_start, btn_sel, btn_inc, btn_clear;
   logic [3:0] seconds, tens_seconds, minutes, tens_minutes;
   logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
   logic       load, timer_on, alarm;
   logic [1:0] digit_sel, state_out;

   int n_checks = 0;
   int n_fail   = 0;

   // model state (plain integers, live count as total seconds)
   int m_state, m_sel, m_acnt, m_live;
   int m_prog[4];
   bit m_prev_zero;
   // environment time_count, driven by the DUT's own load/timer_on
   int e_live;

   eggtimer_ctrl #(.ALARM_SECS(ALARM_SECS)) dut (
      .clk(clk), .reset(reset), .pulse_1s(pulse_1s),
      .btn_start(btn_start), .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_clear(btn_clear),
      .seconds(seconds), .tens_seconds(tens_seconds), .minutes(minutes), .tens_minutes(tens_minutes),
      .seconds_prog(seconds_prog), .tens_seconds_prog(tens_seconds_prog),
      .minutes_prog(minutes_prog), .tens_minutes_prog(tens_minutes_prog),
      .load(load), .timer_on(timer_on), .digit_sel(digit_sel), .alarm(alarm), .state_out(state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_live();
      seconds      = 4'(e_live % 10);
      tens_seconds = 4'((e_live / 10) % 6);
      minutes      = 4'((e_live / 60) % 10);
      tens_minutes = 4'((e_live / 600) % 10);
   endtask

   task automatic model_reset();
      m_state = S_SET; m_sel = 0; m_acnt = 0; m_live = 0; m_prev_zero = 1'b0;
      for (int i = 0; i < 4; i++) m_prog[i] = 0;
      e_live = 0;
      drive_live();
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_edge(input bit st, input bit sl, input bit ic, input bit cl, input bit pl);
      int  old_state, old_live, ptot;
      bit  zero_now, any;
      old_state = m_state;
      old_live  = m_live;
      ptot = m_prog[3] * 600 + m_prog[2] * 60 + m_prog[1] * 10 + m_prog[0];
      if (old_state == S_SET) m_live = ptot;
      else if (old_state == S_RUN && pl) m_live = (old_live == 0) ? 5999 : old_live - 1;
      zero_now = (old_state == S_RUN) && (old_live == 0);
      any = st | sl | ic | cl;
      case (old_state)
         S_SET: begin
            if (cl) begin
               for (int i = 0; i < 4; i++) m_prog[i] = 0;
               m_sel = 0;
            end else if (st) begin
               if (ptot != 0) m_state = S_RUN;
            end else if (sl) begin
               m_sel = (m_sel + 1) % 4;
            end else if (ic) begin
               m_prog[m_sel] = (m_prog[m_sel] + 1) % ((m_sel == 1) ? 6 : 10);
            end
         end
         S_RUN: begin
            if (m_prev_zero) begin m_state = S_ALARM; m_acnt = 0; end
            else if (cl) m_state = S_SET;
            else if (st) m_state = S_PAUSE;
         end
         S_PAUSE: begin
            if (cl) m_state = S_SET;
            else if (st) m_state = S_RUN;
         end
         S_ALARM: begin
            if (any) m_state = S_SET;
            else if (pl) begin
               m_acnt++;
               if (m_acnt == ALARM_SECS) m_state = S_SET;
            end
         end
         default: m_state = S_SET;
      endcase
      m_prev_zero = zero_now;
   endtask

   // Apply inputs for one cycle; inputs change 1ns after each rising edge.
   task automatic step(input bit st, input bit sl, input bit ic, input bit cl, input bit pl);
      logic d_load, d_on;
      int   d_prog, e_next;
      btn_start = st; btn_sel = sl; btn_inc = ic; btn_clear = cl; pulse_1s = pl;
      d_load = load;
      d_on   = timer_on;
      d_prog = int'(tens_minutes_prog) * 600 + int'(minutes_prog) * 60
             + int'(tens_seconds_prog) * 10 + int'(seconds_prog);
      @(posedge clk);
      model_edge(st, sl, ic, cl, pl);
      if (d_load) e_next = d_prog;
      else if (d_on && pl) e_next = (e_live == 0) ? 5999 : e_live - 1;
      else e_next = e_live;
      #1;
      btn_start = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0; btn_clear = 1'b0; pulse_1s = 1'b0;
      e_live = e_next;
      drive_live();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_ticks(input int n);
      repeat (n) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         idle(2);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      btn_start = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0; btn_clear = 1'b0; pulse_1s = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL reset_load got=%0b exp=1", load); end
      n_checks++; if (timer_on !== 1'b0) begin n_fail++; $display("FAIL reset_timer_on got=%0b exp=0", timer_on); end
      n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm got=%0b exp=0", alarm); end
      n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_out); end
      n_checks++;
      if ({tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog, digit_sel} !== 18'd0) begin
         n_fail++; $display("FAIL reset_prog got=%h%h%h%h sel=%0d exp=0000 sel=0",
                            tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog, digit_sel);
      end
   endtask

   task automatic test_digit_edit();
      repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (minutes_prog !== 4'd3) begin n_fail++; $display("FAIL edit_min3 got=%0d exp=3", minutes_prog); end
      n_checks++; if (digit_sel !== 2'd2) begin n_fail++; $display("FAIL edit_sel got=%0d exp=2", digit_sel); end
      repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (minutes_prog !== 4'd1) begin n_fail++; $display("FAIL edit_min_wrap got=%0d exp=1", minutes_prog); end
   endtask

   task automatic test_tens_wrap();
      logic [3:0] exp_ts;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (digit_sel !== 2'd0 || minutes_prog !== 4'd0) begin
         n_fail++; $display("FAIL clear_set got sel=%0d min=%0d exp sel=0 min=0", digit_sel, minutes_prog); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         exp_ts = 4'(i % 6);
         n_checks++; if (tens_seconds_prog !== exp_ts) begin
            n_fail++; $display("FAIL tsec_wrap step=%0d got=%0d exp=%0d", i, tens_seconds_prog, exp_ts); end
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (state_out !== 2'd0 || load !== 1'b1) begin
         n_fail++; $display("FAIL start_zero got state=%0d load=%0b exp state=0 load=1", state_out, load); end
   endtask

   task automatic test_run_expiry();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (timer_on !== 1'b1 || load !== 1'b0) begin
         n_fail++; $display("FAIL start_latency got on=%0b load=%0b exp on=1 load=0", timer_on, load); end
      n_checks++; if (e_live !== 5) begin n_fail++; $display("FAIL start_live got=%0d exp=5", e_live); end
      run_ticks(4);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (e_live !== 0 || timer_on !== 1'b1) begin
         n_fail++; $display("FAIL expiry_T got live=%0d on=%0b exp live=0 on=1", e_live, timer_on); end
      idle(1);
      n_checks++; if (timer_on !== 1'b1 || alarm !== 1'b0) begin
         n_fail++; $display("FAIL expiry_T1 got on=%0b alarm=%0b exp on=1 alarm=0", timer_on, alarm); end
      idle(1);
      n_checks++; if (timer_on !== 1'b0 || alarm !== 1'b1 || state_out !== 2'd3) begin
         n_fail++; $display("FAIL expiry_T2 got on=%0b alarm=%0b state=%0d exp on=0 alarm=1 state=3",
                            timer_on, alarm, state_out); end
   endtask

   task automatic test_alarm_timeout();
      run_ticks(2);
      n_checks++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_hold got=%0b exp=1", alarm); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (state_out !== 2'd0 || load !== 1'b1 || alarm !== 1'b0) begin
         n_fail++; $display("FAIL alarm_timeout got state=%0d load=%0b alarm=%0b exp 0/1/0", state_out, load, alarm); end
      n_checks++; if ({tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} !== 16'h0005) begin
         n_fail++; $display("FAIL alarm_keep_prog got=%h%h%h%h exp=0005",
                            tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog); end
   endtask

   task automatic test_alarm_button();
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_ticks(5);
      n_checks++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_again got=%0b exp=1", alarm); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (state_out !== 2'd0 || alarm !== 1'b0) begin
         n_fail++; $display("FAIL alarm_btn got state=%0d alarm=%0b exp 0/0", state_out, alarm); end
      n_checks++; if (minutes_prog !== 4'd0 || seconds_prog !== 4'd5) begin
         n_fail++; $display("FAIL alarm_btn_prog got min=%0d sec=%0d exp min=0 sec=5", minutes_prog, seconds_prog); end
   endtask

   task automatic test_pause();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_ticks(2);
      n_checks++; if (e_live !== 58) begin n_fail++; $display("FAIL pause_run got=%0d exp=58", e_live); end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (state_out !== 2'd2 || timer_on !== 1'b0) begin
         n_fail++; $display("FAIL pause_enter got state=%0d on=%0b exp 2/0", state_out, timer_on); end
      run_ticks(5);
      n_checks++; if (e_live !== 58) begin n_fail++; $display("FAIL pause_hold got=%0d exp=58", e_live); end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (state_out !== 2'd1 || timer_on !== 1'b1) begin
         n_fail++; $display("FAIL pause_resume got state=%0d on=%0b exp 1/1", state_out, timer_on); end
      run_ticks(1);
      n_checks++; if (e_live !== 57) begin n_fail++; $display("FAIL resume_count got=%0d exp=57", e_live); end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      n_checks++; if (state_out !== 2'd0 || e_live !== 60) begin
         n_fail++; $display("FAIL clear_reload got state=%0d live=%0d exp 0/60", state_out, e_live); end
   endtask

   task automatic test_simul_clear_start();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (state_out !== 2'd0 || load !== 1'b1) begin
         n_fail++; $display("FAIL clear_over_start got state=%0d load=%0b exp 0/1", state_out, load); end
   endtask

   task automatic test_async_reset();
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_ticks(1);
      #3 reset = 1'b0;
      #1;
      n_checks++; if (timer_on !== 1'b0 || load !== 1'b1 || minutes_prog !== 4'd0 || state_out !== 2'd0) begin
         n_fail++; $display("FAIL async_reset got on=%0b load=%0b min=%0d state=%0d exp 0/1/0/0",
                            timer_on, load, minutes_prog, state_out); end
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_random();
      int gap;
      gap = 2;
      for (int c = 0; c < 4000; c++) begin
         bit st, sl, ic, cl, pl;
         st = ($urandom_range(0, 15) == 0);
         sl = ($urandom_range(0, 9) == 0);
         ic = ($urandom_range(0, 3) == 0);
         cl = ($urandom_range(0, 59) == 0);
         pl = (gap >= 2) && ($urandom_range(0, 1) == 0);
         gap = pl ? 0 : gap + 1;
         step(st, sl, ic, cl, pl);
         n_checks++; if (int'(state_out) !== m_state) begin
            n_fail++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", c, state_out, m_state); end
         n_checks++; if (load !== (m_state == S_SET) || timer_on !== (m_state == S_RUN) || alarm !== (m_state == S_ALARM)) begin
            n_fail++; $display("FAIL rnd_outs cyc=%0d got load=%0b on=%0b alarm=%0b exp_state=%0d",
                               c, load, timer_on, alarm, m_state); end
         n_checks++; if (int'(digit_sel) !== m_sel) begin
            n_fail++; $display("FAIL rnd_sel cyc=%0d got=%0d exp=%0d", c, digit_sel, m_sel); end
         n_checks++;
         if (int'(seconds_prog) !== m_prog[0] || int'(tens_seconds_prog) !== m_prog[1] ||
             int'(minutes_prog) !== m_prog[2] || int'(tens_minutes_prog) !== m_prog[3]) begin
            n_fail++; $display("FAIL rnd_prog cyc=%0d got=%0d%0d:%0d%0d exp=%0d%0d:%0d%0d", c,
                               tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog,
                               m_prog[3], m_prog[2], m_prog[1], m_prog[0]); end
         n_checks++; if (e_live !== m_live) begin
            n_fail++; $display("FAIL rnd_live cyc=%0d got=%0d exp=%0d", c, e_live, m_live); end
      end
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_digit_edit();
      test_tens_wrap();
      test_run_expiry();
      test_alarm_timeout();
      test_alarm_button();
      test_pause();
      test_simul_clear_start();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
